gb_bcd_rtc: RTL and testbench

Parametrised BCD calendar RTC core shared by all RTC-capable cartridge mappers: TAMA5, MBC3-style and HuC3 register front ends.
- Counts seconds, minutes, hours, day, month and year in packed BCD, with 12/24-hour mode and a 2-bit leap-year phase.
- Supports halting, field writes from the mapper, and a latched read snapshot.
- Adds a catch-up engine that fast-forwards by a host-supplied elapsed-second count, one second per clock. This covers real time that passed while the core was off or a savestate was loaded.

---
 rtl/gb_rtc_pkg.sv | 47 ++++
 rtl/bcd_field_inc.sv | 29 ++
 rtl/gb_bcd_rtc.sv | 206 ++++++++++++++++++++
 tb/tb_gb_bcd_rtc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gb_rtc_pkg.sv
// Shared definitions for the BCD calendar RTC core: field indices, reset
// values and the month-length helper used by the day rollover.
package gb_rtc_pkg;

    localparam logic [2:0] RTC_SEC   = 3'd0;
    localparam logic [2:0] RTC_MIN   = 3'd1;
    localparam logic [2:0] RTC_HOUR  = 3'd2;
    localparam logic [2:0] RTC_DAY   = 3'd3;
    localparam logic [2:0] RTC_MONTH = 3'd4;
    localparam logic [2:0] RTC_YEAR  = 3'd5;
    localparam logic [2:0] RTC_CTRL  = 3'd6;

    // All calendar fields in packed BCD, most significant field first so the
    // struct lines up with the savestate word.
    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] sec;
    } rtcTime_t;

    localparam rtcTime_t RTC_RESET_TIME = '{
        year:   8'h00,
        month:  8'h01,
        day:    8'h01,
        hour:   8'h00,
        minute: 8'h00,
        sec:    8'h00
    };
    localparam logic       RTC_RESET_MODE24 = 1'b1;
    localparam logic [1:0] RTC_RESET_LEAP   = 2'd0;

    // Last valid day of a month; leap phase 0 is the leap year of the cycle.
    function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                 input logic [1:0] leap);
        logic [7:0] result;
        case (month)
            8'h04, 8'h06, 8'h09, 8'h11: result = 8'h30;
            8'h02:                      result = (leap == 2'd0) ? 8'h29 : 8'h28;
            default:                    result = 8'h31;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bcd_field_inc.sv
// One BCD digit pair of the calendar carry chain. A field at or above its
// maximum wraps and carries on; anything else counts up in BCD.
module bcd_field_inc (
    input  logic [7:0] value_i,
    input  logic [7:0] max_i,
    input  logic [7:0] wrap_i,
    input  logic       carry_i,
    output logic [7:0] next_o,
    output logic       carry_o
);

    // The >= compare lets out-of-range values written by the mapper fall back
    // into range at their next rollover instead of counting on forever.
    always_comb begin
        next_o  = value_i;
        carry_o = 1'b0;
        if (carry_i) begin
            if (value_i >= max_i) begin
                next_o  = wrap_i;
                carry_o = 1'b1;
            end else if (value_i[3:0] == 4'h9) begin
                next_o = {value_i[7:4] + 4'h1, 4'h0};
            end else begin
                next_o = value_i + 8'h01;
            end
        end
    end

endmodule

// File: rtl/gb_bcd_rtc.sv
// BCD calendar RTC shared by the TAMA5, MBC3-style and HuC3 front ends.
// Real-time seconds come from a ce_1x divider; a catch-up engine replays
// seconds that elapsed while the core was not running, one per clock.
module gb_bcd_rtc
    import gb_rtc_pkg::*;
#(
    parameter int SUBSEC_DIV     = 4194304,
    parameter int CW             = 32,
    parameter bit HAS_SECONDS_RD = 1'b1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_1x,
    input  logic          halt,
    input  logic          wr,
    input  logic [2:0]    wr_idx,
    input  logic [7:0]    wr_data,
    input  logic          latch,
    input  logic [2:0]    rd_idx,
    output logic [7:0]    rd_data,
    input  logic          catchup_load,
    input  logic [CW-1:0] catchup_secs,
    output logic          busy,
    output logic          sec_pulse,
    output logic [47:0]   live_time
);

    localparam int              SS_W        = (SUBSEC_DIV > 1) ? $clog2(SUBSEC_DIV) : 1;
    localparam logic [SS_W-1:0] SUBSEC_LAST = SS_W'(SUBSEC_DIV - 1);

    rtcTime_t        live_q, live_d, snap_q;
    logic            mode24_q, mode24_d, snapMode24_q;
    logic [1:0]      leap_q, leap_d, snapLeap_q;
    logic [SS_W-1:0] subSec_q, subSec_d;
    logic [CW-1:0]   pending_q, pending_d, pendingBase;
    logic [CW:0]     pendingSum;
    logic            busy_q, secPulse_q;

    logic            subTick, rtEvent, pendingNz, applyInc;
    logic [7:0]      secNext, minNext, hour24Next, hour12Next, hourNext;
    logic [7:0]      dayNext, monthNext, yearNext;
    logic            secCarry, minCarry, hour24Carry, dayCarry12, hourCarry;
    logic            dayCarry, monthCarry, yearCarry;
    logic [4:0]      hour12;

    assign subTick   = ce_1x & ~halt;
    assign rtEvent   = subTick & (subSec_q == SUBSEC_LAST);
    assign pendingNz = (pending_q != '0);
    assign applyInc  = pendingNz | rtEvent;

    // A catch-up second and a real-time second in the same cycle cancel out
    // on the pending count, so only one increment is ever applied per clock.
    always_comb begin
        pendingBase = pending_q;
        if (pendingNz && !rtEvent) begin
            pendingBase = pending_q - CW'(1);
        end
        pendingSum = {1'b0, pendingBase} + {1'b0, catchup_secs};
        pending_d  = pendingBase;
        if (catchup_load) begin
            pending_d = pendingSum[CW] ? '1 : pendingSum[CW-1:0];
        end
    end

    bcd_field_inc u_secInc (
        .value_i(live_q.sec), .max_i(8'h59), .wrap_i(8'h00), .carry_i(applyInc),
        .next_o(secNext), .carry_o(secCarry)
    );

    bcd_field_inc u_minInc (
        .value_i(live_q.minute), .max_i(8'h59), .wrap_i(8'h00), .carry_i(secCarry),
        .next_o(minNext), .carry_o(minCarry)
    );

    bcd_field_inc u_hour24Inc (
        .value_i(live_q.hour), .max_i(8'h23), .wrap_i(8'h00), .carry_i(minCarry),
        .next_o(hour24Next), .carry_o(hour24Carry)
    );

    // 12-hour clock: bit 5 is PM, the low bits run 01..12; the day only turns
    // over when PM 11 becomes AM 12.
    always_comb begin
        hour12     = live_q.hour[4:0];
        hour12Next = live_q.hour;
        dayCarry12 = 1'b0;
        if (minCarry) begin
            if (hour12 >= 5'h12) begin
                hour12Next = {2'b00, live_q.hour[5], 5'h01};
            end else if (hour12 == 5'h11) begin
                hour12Next = {2'b00, ~live_q.hour[5], 5'h12};
                dayCarry12 = live_q.hour[5];
            end else if (hour12[3:0] == 4'h9) begin
                hour12Next = {2'b00, live_q.hour[5], 5'h10};
            end else begin
                hour12Next = {2'b00, live_q.hour[5], hour12 + 5'h01};
            end
        end
    end

    assign hourNext  = mode24_q ? hour24Next  : hour12Next;
    assign hourCarry = mode24_q ? hour24Carry : dayCarry12;

    bcd_field_inc u_dayInc (
        .value_i(live_q.day), .max_i(days_in_month(live_q.month, leap_q)),
        .wrap_i(8'h01), .carry_i(hourCarry),
        .next_o(dayNext), .carry_o(dayCarry)
    );

    bcd_field_inc u_monthInc (
        .value_i(live_q.month), .max_i(8'h12), .wrap_i(8'h01), .carry_i(dayCarry),
        .next_o(monthNext), .carry_o(monthCarry)
    );

    bcd_field_inc u_yearInc (
        .value_i(live_q.year), .max_i(8'h99), .wrap_i(8'h00), .carry_i(monthCarry),
        .next_o(yearNext), .carry_o(yearCarry)
    );

    // Mapper writes land on top of the incremented values, so a written
    // field simply drops whatever carry arrived in the same cycle.
    always_comb begin
        live_d.sec    = secNext;
        live_d.minute = minNext;
        live_d.hour   = hourNext;
        live_d.day    = dayNext;
        live_d.month  = monthNext;
        live_d.year   = yearNext;
        mode24_d      = mode24_q;
        leap_d        = monthCarry ? leap_q + 2'd1 : leap_q;
        subSec_d      = subSec_q;
        if (subTick) begin
            subSec_d = rtEvent ? '0 : subSec_q + SS_W'(1);
        end
        if (wr) begin
            case (wr_idx)
                RTC_SEC: begin
                    live_d.sec = wr_data;
                    subSec_d   = '0;
                end
                RTC_MIN:   live_d.minute = wr_data;
                RTC_HOUR:  live_d.hour   = wr_data;
                RTC_DAY:   live_d.day    = wr_data;
                RTC_MONTH: live_d.month  = wr_data;
                RTC_YEAR:  live_d.year   = wr_data;
                RTC_CTRL: begin
                    mode24_d = wr_data[0];
                    leap_d   = wr_data[2:1];
                end
                default: ;
            endcase
        end
    end

    // State registers; the snapshot copies the pre-update live values so a
    // latch coinciding with a write or a tick still sees the old time.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            live_q       <= RTC_RESET_TIME;
            mode24_q     <= RTC_RESET_MODE24;
            leap_q       <= RTC_RESET_LEAP;
            snap_q       <= RTC_RESET_TIME;
            snapMode24_q <= RTC_RESET_MODE24;
            snapLeap_q   <= RTC_RESET_LEAP;
            subSec_q     <= '0;
            pending_q    <= '0;
            busy_q       <= 1'b0;
            secPulse_q   <= 1'b0;
        end else begin
            live_q     <= live_d;
            mode24_q   <= mode24_d;
            leap_q     <= leap_d;
            subSec_q   <= subSec_d;
            pending_q  <= pending_d;
            busy_q     <= (pending_d != '0);
            secPulse_q <= applyInc;
            if (latch) begin
                snap_q       <= live_q;
                snapMode24_q <= mode24_q;
                snapLeap_q   <= leap_q;
            end
        end
    end

    // Read port is a plain mux over the snapshot; some mappers hide seconds.
    always_comb begin
        rd_data = 8'h00;
        case (rd_idx)
            RTC_SEC:   rd_data = HAS_SECONDS_RD ? snap_q.sec : 8'h00;
            RTC_MIN:   rd_data = snap_q.minute;
            RTC_HOUR:  rd_data = snap_q.hour;
            RTC_DAY:   rd_data = snap_q.day;
            RTC_MONTH: rd_data = snap_q.month;
            RTC_YEAR:  rd_data = snap_q.year;
            RTC_CTRL:  rd_data = {5'b00000, snapLeap_q, snapMode24_q};
            default:   rd_data = 8'h00;
        endcase
    end

    assign busy      = busy_q;
    assign sec_pulse = secPulse_q;
    assign live_time = {live_q.year, live_q.month, live_q.day,
                        2'b00, live_q.hour[5:0],
                        1'b0, live_q.minute[6:0],
                        1'b0, live_q.sec[6:0]};

endmodule

// File: tb/tb_gb_bcd_rtc.sv
// Directed bench for gb_bcd_rtc: rollovers in both hour modes, leap years,
// catch-up racing real-time seconds, latch ordering, halt and reset.
module tb_gb_bcd_rtc;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce_1x = 1'b0;
    logic        halt = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  wr_idx = 3'd0;
    logic [7:0]  wr_data = 8'h00;
    logic        latch = 1'b0;
    logic [2:0]  rd_idx = 3'd0;
    logic        catchup_load = 1'b0;
    logic [31:0] catchup_secs = 32'd0;

    logic [7:0]  rd_data, rd_data_ns;
    logic        busy, busy_ns, sec_pulse, sec_pulse_ns;
    logic [47:0] live_time, live_time_ns;

    int checkCount = 0;
    int errorCount = 0;

    gb_bcd_rtc #(.SUBSEC_DIV(4), .CW(32), .HAS_SECONDS_RD(1'b1)) u_dut (
        .clk_sys(clk_sys), .reset(reset), .ce_1x(ce_1x), .halt(halt),
        .wr(wr), .wr_idx(wr_idx), .wr_data(wr_data), .latch(latch),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .catchup_load(catchup_load), .catchup_secs(catchup_secs),
        .busy(busy), .sec_pulse(sec_pulse), .live_time(live_time)
    );

    gb_bcd_rtc #(.SUBSEC_DIV(4), .CW(32), .HAS_SECONDS_RD(1'b0)) u_dutNoSec (
        .clk_sys(clk_sys), .reset(reset), .ce_1x(ce_1x), .halt(halt),
        .wr(wr), .wr_idx(wr_idx), .wr_data(wr_data), .latch(latch),
        .rd_idx(rd_idx), .rd_data(rd_data_ns),
        .catchup_load(catchup_load), .catchup_secs(catchup_secs),
        .busy(busy_ns), .sec_pulse(sec_pulse_ns), .live_time(live_time_ns)
    );

    always #5 clk_sys = ~clk_sys;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [47:0] observed,
                               input logic [47:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic writeField(input logic [2:0] idx, input logic [7:0] data);
        wr = 1'b1;
        wr_idx = idx;
        wr_data = data;
        tick;
        wr = 1'b0;
    endtask

    task automatic applyStimulus(input int secs);
        catchup_load = 1'b1;
        catchup_secs = secs;
        tick;
        catchup_load = 1'b0;
        catchup_secs = 32'd0;
        for (int i = 0; i < secs; i++) tick;
    endtask

    task automatic setClock(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        writeField(3'd2, h);
        writeField(3'd1, m);
        writeField(3'd0, s);
    endtask

    function automatic logic [7:0] toBcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    int pulses;
    int busyCycles;
    int ceCount;
    int events;
    int total;
    bit done;

    // Directed test sequence.
    initial begin
        tick;
        tick;
        reset = 1'b0;

        checkOutput("rst_live", live_time, 48'h00_01_01_00_00_00);
        checkOutput("rst_busy", 48'(busy), 48'h0);
        checkOutput("rst_pulse", 48'(sec_pulse), 48'h0);
        rd_idx = 3'd3; #1;
        checkOutput("rst_snapDay", 48'(rd_data), 48'h01);
        rd_idx = 3'd6; #1;
        checkOutput("rst_snapCtrl", 48'(rd_data), 48'h01);

        // Real-time seconds from the divider
        writeField(3'd0, 8'h58);
        pulses = 0;
        ce_1x = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (sec_pulse) pulses++;
        end
        ce_1x = 1'b0;
        checkOutput("t1_pulses", 48'(pulses), 48'd2);
        checkOutput("t1_minSec", 48'(live_time[15:0]), 48'h0100);

        // Feb 28 rollover, leap phase 0 (29 days)
        writeField(3'd6, 8'h01);
        setClock(8'h23, 8'h59, 8'h59);
        writeField(3'd3, 8'h28);
        writeField(3'd4, 8'h02);
        catchup_load = 1'b1; catchup_secs = 32'd1; tick;
        catchup_load = 1'b0; catchup_secs = 32'd0;
        checkOutput("t2_busyRise", 48'(busy), 48'h1);
        tick;
        checkOutput("t2_leapPulse", 48'(sec_pulse), 48'h1);
        checkOutput("t2_leapDate", live_time[47:16], 48'h00_02_29_00);

        // Same moment with leap phase 1 (28 days)
        writeField(3'd6, 8'h03);
        setClock(8'h23, 8'h59, 8'h59);
        writeField(3'd3, 8'h28);
        writeField(3'd4, 8'h02);
        applyStimulus(1);
        checkOutput("t2_noLeapDate", live_time[47:16], 48'h00_03_01_00);

        // 12-hour mode transitions
        writeField(3'd6, 8'h00);
        writeField(3'd3, 8'h10);
        setClock(8'h11, 8'h59, 8'h59);
        applyStimulus(1);
        checkOutput("t3_amToPm", 48'(live_time[31:0]), 48'h10_32_00_00);
        setClock(8'h32, 8'h59, 8'h59);
        applyStimulus(1);
        checkOutput("t3_pm12To1", 48'(live_time[23:16]), 48'h21);
        setClock(8'h31, 8'h59, 8'h59);
        applyStimulus(1);
        checkOutput("t3_pmToAm", 48'(live_time[31:0]), 48'h11_12_00_00);

        // End of century with leap phase wrap
        writeField(3'd6, 8'h07);
        writeField(3'd4, 8'h12);
        writeField(3'd3, 8'h31);
        writeField(3'd5, 8'h99);
        setClock(8'h23, 8'h59, 8'h59);
        applyStimulus(1);
        checkOutput("t4_newYear", live_time, 48'h00_01_01_00_00_00);
        latch = 1'b1; tick; latch = 1'b0;
        rd_idx = 3'd6; #1;
        checkOutput("t4_ctrl", 48'(rd_data), 48'h01);

        // One hour of catch-up racing real-time seconds
        writeField(3'd0, 8'h00);
        catchup_load = 1'b1; catchup_secs = 32'd3600; tick;
        catchup_load = 1'b0; catchup_secs = 32'd0;
        busyCycles = busy ? 1 : 0;
        ceCount = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 10000 && !done; cyc++) begin
            ce_1x = ((cyc % 10) >= 6);
            if (ce_1x) ceCount++;
            tick;
            if (busy) busyCycles++;
            else done = 1'b1;
        end
        ce_1x = 1'b0;
        checkOutput("t5_busyDrop", 48'(busy), 48'h0);
        events = ceCount / 4;
        total = 3600 + events;
        checkOutput("t5_busyLen", 48'(busyCycles), 48'(total));
        checkOutput("t5_time", 48'(live_time[23:0]),
                    48'({toBcd(total / 3600), toBcd((total / 60) % 60), toBcd(total % 60)}));
        repeat (5) tick;
        checkOutput("t5_noUnderflow", 48'(busy), 48'h0);

        // Latch ordering and hidden seconds
        writeField(3'd0, 8'h05);
        latch = 1'b1; tick; latch = 1'b0;
        writeField(3'd0, 8'h30);
        applyStimulus(3);
        rd_idx = 3'd0; #1;
        checkOutput("t6_snapSec", 48'(rd_data), 48'h05);
        checkOutput("t6_liveSec", 48'(live_time[7:0]), 48'h33);
        checkOutput("t6_hiddenSec", 48'(rd_data_ns), 48'h00);
        latch = 1'b1; wr = 1'b1; wr_idx = 3'd0; wr_data = 8'h40;
        tick;
        latch = 1'b0; wr = 1'b0;
        checkOutput("t6_latchPreWrite", 48'(rd_data), 48'h33);
        checkOutput("t6_writeWins", 48'(live_time[7:0]), 48'h40);

        // Halt freezes real time but not catch-up
        halt = 1'b1;
        ce_1x = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (sec_pulse) pulses++;
        end
        ce_1x = 1'b0;
        checkOutput("t7_haltPulses", 48'(pulses), 48'd0);
        applyStimulus(1);
        checkOutput("t7_haltCatchup", 48'(live_time[7:0]), 48'h41);
        halt = 1'b0;

        // Reset in the middle of a catch-up
        catchup_load = 1'b1; catchup_secs = 32'd100; tick;
        catchup_load = 1'b0; catchup_secs = 32'd0;
        repeat (3) tick;
        reset = 1'b1; tick; reset = 1'b0;
        checkOutput("t8_busyCleared", 48'(busy), 48'h0);
        checkOutput("t8_liveReset", live_time, 48'h00_01_01_00_00_00);
        rd_idx = 3'd0; #1;
        checkOutput("t8_snapReset", 48'(rd_data), 48'h00);
        tick;
        checkOutput("t8_staysIdle", 48'(live_time[7:0]), 48'h00);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
